// File: rtl/kb_scan_decoder.sv
// PS/2 set-2 scan-code decoder: strobe synchronizer, prefix FSM with timeout, key-event outputs.
// Define KB_ASCII_EN to add shift/caps tracking and make-code to ASCII translation.
module kb_scan_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_scan_code,
  input  logic       i_byte_strobe,
  output logic       o_key_valid,
  output logic [7:0] o_key_code,
  output logic       o_key_ext,
  output logic       o_key_release,
  output logic [7:0] o_ascii,
  output logic       o_shift,
  output logic       o_caps,
  output logic       o_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t           state;
  state_t           byte_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             sync1, sync2, hist, sync_valid, armed;
  logic             byte_edge, byte_event, byte_err;
  logic             ev_ext, ev_rel;

  // A level already high at reset release must first be seen low before it can count as an edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      hist       <= 1'b0;
      sync_valid <= 1'b0;
      armed      <= 1'b0;
    end else begin
      sync1      <= i_byte_strobe;
      sync2      <= sync1;
      hist       <= sync2;
      sync_valid <= 1'b1;
      armed      <= armed | (sync_valid & ~sync1);
    end
  end

  assign byte_edge = sync2 & ~hist & armed;
  assign ev_ext    = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign ev_rel    = (state == ST_BRK) || (state == ST_EXT_BRK);

  // Classify the incoming byte against the current prefix state
  always_comb begin
    byte_next  = ST_IDLE;
    byte_event = 1'b0;
    byte_err   = 1'b0;
    case (i_scan_code)
      8'h00, 8'hFF: byte_err = 1'b1;
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1: byte_err = 1'b0;
      8'hE0: begin
        byte_next = ST_EXT;
        byte_err  = (state != ST_IDLE);
      end
      8'hF0: begin
        byte_next = (state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
        byte_err  = (state == ST_BRK) || (state == ST_EXT_BRK);
      end
      default: byte_event = 1'b1;
    endcase
  end

  // Prefix FSM, timeout counter and event outputs; a byte edge always beats timeout expiry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      tmo_cnt       <= '0;
      o_key_valid   <= 1'b0;
      o_key_code    <= 8'h00;
      o_key_ext     <= 1'b0;
      o_key_release <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      o_error     <= 1'b0;
      if (byte_edge) begin
        tmo_cnt <= '0;
        state   <= byte_next;
        o_error <= byte_err;
        if (byte_event) begin
          o_key_valid   <= 1'b1;
          o_key_code    <= i_scan_code;
          o_key_ext     <= ev_ext;
          o_key_release <= ev_rel;
        end
      end else if (state != ST_IDLE) begin
        if (tmo_cnt == CNT_MAX) begin
          state   <= ST_IDLE;
          o_error <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef KB_ASCII_EN
  logic       shift_l, shift_r, caps_held;
  logic       shift_l_d, shift_r_d, caps_held_d, caps_d;
  logic [7:0] lut_ascii, ev_ascii;
  logic       lut_letter;

  // Set-2 make code to lowercase ASCII
  always_comb begin
    lut_ascii = 8'h00;
    case (i_scan_code)
      8'h1C: lut_ascii = 8'h61; 8'h32: lut_ascii = 8'h62; 8'h21: lut_ascii = 8'h63;
      8'h23: lut_ascii = 8'h64; 8'h24: lut_ascii = 8'h65; 8'h2B: lut_ascii = 8'h66;
      8'h34: lut_ascii = 8'h67; 8'h33: lut_ascii = 8'h68; 8'h43: lut_ascii = 8'h69;
      8'h3B: lut_ascii = 8'h6A; 8'h42: lut_ascii = 8'h6B; 8'h4B: lut_ascii = 8'h6C;
      8'h3A: lut_ascii = 8'h6D; 8'h31: lut_ascii = 8'h6E; 8'h44: lut_ascii = 8'h6F;
      8'h4D: lut_ascii = 8'h70; 8'h15: lut_ascii = 8'h71; 8'h2D: lut_ascii = 8'h72;
      8'h1B: lut_ascii = 8'h73; 8'h2C: lut_ascii = 8'h74; 8'h3C: lut_ascii = 8'h75;
      8'h2A: lut_ascii = 8'h76; 8'h1D: lut_ascii = 8'h77; 8'h22: lut_ascii = 8'h78;
      8'h35: lut_ascii = 8'h79; 8'h1A: lut_ascii = 8'h7A;
      8'h45: lut_ascii = 8'h30; 8'h16: lut_ascii = 8'h31; 8'h1E: lut_ascii = 8'h32;
      8'h26: lut_ascii = 8'h33; 8'h25: lut_ascii = 8'h34; 8'h2E: lut_ascii = 8'h35;
      8'h36: lut_ascii = 8'h36; 8'h3D: lut_ascii = 8'h37; 8'h3E: lut_ascii = 8'h38;
      8'h46: lut_ascii = 8'h39;
      8'h29: lut_ascii = 8'h20; 8'h5A: lut_ascii = 8'h0D; 8'h66: lut_ascii = 8'h08;
      default: lut_ascii = 8'h00;
    endcase
  end

  assign lut_letter = (lut_ascii >= 8'h61) && (lut_ascii <= 8'h7A);
  assign ev_ascii   = (ev_ext || ev_rel) ? 8'h00 :
                      (lut_letter && ((shift_l | shift_r) ^ o_caps)) ? (lut_ascii - 8'h20) :
                      lut_ascii;

  // Modifier tracking; caps toggles only on the first make after a break
  always_comb begin
    shift_l_d   = shift_l;
    shift_r_d   = shift_r;
    caps_held_d = caps_held;
    caps_d      = o_caps;
    if (byte_edge && byte_event && !ev_ext) begin
      case (i_scan_code)
        8'h12: shift_l_d = ~ev_rel;
        8'h59: shift_r_d = ~ev_rel;
        8'h58: begin
          if (!ev_rel && !caps_held) caps_d = ~o_caps;
          caps_held_d = ~ev_rel;
        end
        default: caps_held_d = caps_held;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_held <= 1'b0;
      o_caps    <= 1'b0;
      o_shift   <= 1'b0;
      o_ascii   <= 8'h00;
    end else begin
      shift_l   <= shift_l_d;
      shift_r   <= shift_r_d;
      caps_held <= caps_held_d;
      o_caps    <= caps_d;
      o_shift   <= shift_l_d | shift_r_d;
      if (byte_edge && byte_event) o_ascii <= ev_ascii;
    end
  end
`else
  assign o_ascii = 8'h00;
  assign o_shift = 1'b0;
  assign o_caps  = 1'b0;
`endif

endmodule

// File: tb/tb_kb_scan_decoder.sv
// Directed + randomized bench for kb_scan_decoder against a prefix-flag reference model.
`timescale 1ns/1ps
module tb_kb_scan_decoder;
  localparam int unsigned TMO = 40;

  logic       clk = 1'b0;
  logic       rst, strobe;
  logic [7:0] code;
  logic       key_valid, key_ext, key_release, shift, caps, error;
  logic [7:0] key_code, ascii;

  kb_scan_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_scan_code(code), .i_byte_strobe(strobe),
    .o_key_valid(key_valid), .o_key_code(key_code), .o_key_ext(key_ext),
    .o_key_release(key_release), .o_ascii(ascii), .o_shift(shift), .o_caps(caps),
    .o_error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] ascii;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  int  cyc = 0, err_seen = 0, exp_err = 0, n_tests = 0, n_fail = 0;

  bit         m_ext, m_rel, m_lsh, m_rsh, m_caps, m_caps_down;
  logic [7:0] last_code, last_ascii;
  logic       last_ext, last_rel;

  byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46};
  byte unsigned quiet_codes[7] = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1};
  byte unsigned special_codes[3] = '{8'h29, 8'h5A, 8'h66};

  // Output monitor: one sample per clock, 1 ns after the edge
  always @(posedge clk) begin
    ev_t e;
    #1;
    cyc++;
    if (key_valid) begin
      e.cyc = cyc; e.code = key_code; e.ext = key_ext; e.rel = key_release; e.ascii = ascii;
      got_q.push_back(e);
    end
    if (error) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input bit upper);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return upper ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return 8'(48 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_rel = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_down = 0;
    last_code = 8'h00; last_ascii = 8'h00; last_ext = 1'b0; last_rel = 1'b0;
  endtask

  // Reference: pending prefix flags; any byte edge fully resolved by these rules
  task automatic model_byte(input logic [7:0] b, input int t_rise);
    bit quiet = 0;
    foreach (quiet_codes[i]) if (quiet_codes[i] == b) quiet = 1;
    if (quiet) begin
      if (b == 8'h00 || b == 8'hFF) exp_err++;
      m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) begin
      if (m_ext || m_rel) exp_err++;
      m_ext = 1; m_rel = 0;
    end else if (b == 8'hF0) begin
      if (m_rel) begin exp_err++; m_ext = 0; end
      m_rel = 1;
    end else begin
      ev_t e;
      e.cyc = t_rise + 3; e.code = b; e.ext = m_ext; e.rel = m_rel; e.ascii = 8'h00;
`ifdef KB_ASCII_EN
      if (!m_ext && !m_rel) e.ascii = model_ascii(b, (m_lsh | m_rsh) ^ m_caps);
      if (!m_ext) begin
        if (b == 8'h12) m_lsh = !m_rel;
        if (b == 8'h59) m_rsh = !m_rel;
        if (b == 8'h58) begin
          if (!m_rel && !m_caps_down) m_caps = !m_caps;
          m_caps_down = !m_rel;
        end
      end
`endif
      exp_q.push_back(e);
      last_code = e.code; last_ext = e.ext; last_rel = e.rel; last_ascii = e.ascii;
      m_ext = 0; m_rel = 0;
    end
  endtask

  task automatic check_events(input string tag);
    ev_t g, x;
    chk({tag, " event count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, " latency cycle"}, g.cyc, x.cyc);
      chk({tag, " code"}, g.code, x.code);
      chk({tag, " ext"}, g.ext, x.ext);
      chk({tag, " release"}, g.rel, x.rel);
      chk({tag, " ascii"}, g.ascii, x.ascii);
    end
    got_q.delete();
    exp_q.delete();
    chk({tag, " error pulses"}, err_seen, exp_err);
    chk({tag, " held code"}, key_code, last_code);
    chk({tag, " held ext"}, key_ext, last_ext);
    chk({tag, " held release"}, key_release, last_rel);
    chk({tag, " held ascii"}, ascii, last_ascii);
    chk({tag, " shift"}, shift, m_lsh | m_rsh);
    chk({tag, " caps"}, caps, m_caps);
  endtask

  task automatic send(input logic [7:0] b);
    int t0;
    t0 = cyc;
    code = b;
    strobe = 1'b1;
    model_byte(b, t0);
    repeat (4) tick();
    strobe = 1'b0;
    repeat (4) tick();
    check_events($sformatf("byte %02h", b));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    chk("reset valid", key_valid, 1'b0);
    chk("reset code", key_code, 8'h00);
    chk("reset ext", key_ext, 1'b0);
    chk("reset release", key_release, 1'b0);
    chk("reset ascii", ascii, 8'h00);
    chk("reset shift", shift, 1'b0);
    chk("reset caps", caps, 1'b0);
    chk("reset error", error, 1'b0);
    rst = 1'b0;
    model_reset();
    repeat (3) tick();
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 11);
    case (r)
      0:       return 8'hE0;
      1, 2:    return 8'hF0;
      3:       return quiet_codes[$urandom_range(0, 6)];
      4:       return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      5:       return 8'h58;
      6, 7, 8: return letter_codes[$urandom_range(0, 25)];
      9:       return digit_codes[$urandom_range(0, 9)];
      10:      return special_codes[$urandom_range(0, 2)];
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; strobe = 1'b0; code = 8'h00;
    model_reset();
    do_reset(3);

    send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h58);

    // Prefix abandoned by timeout: nothing one cycle before expiry, one error after
    send(8'hF0);
    repeat (TMO - 6) tick();
    check_events("timeout pending");
    repeat (3) tick();
    exp_err++;
    m_ext = 0; m_rel = 0;
    check_events("timeout expired");
    send(8'h1C);

    // Byte edge lands on the exact expiry cycle
    send(8'hE0);
    repeat (TMO - 8) tick();
    send(8'h75);

    send(8'hE0); send(8'hE0); send(8'h1C);
    send(8'hF0); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'hE0); send(8'h1C);
    send(8'hE0); send(8'hAA); send(8'h1C);
    send(8'h00); send(8'hFF); send(8'hF0); send(8'hFA); send(8'h5A);

    // Reset mid-sequence drops the prefix silently
    send(8'hE0);
    do_reset(1);
    send(8'h1C);

    // Strobe level held high through reset must not produce an event
    code = 8'h1C;
    strobe = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    repeat (6) tick();
    strobe = 1'b0;
    repeat (4) tick();
    check_events("level through reset");
    send(8'h29);

    for (int i = 0; i < 150; i++) send(pick());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
